// File: rtl/mac_hash_table.sv
// mac_hash_table: single-port MAC learn/lookup table indexed by the low hash bits, 2-cycle response
//
// Ports:
//   clk, reset            clock, synchronous active-high reset (table is re-cleared after reset)
//   req_valid/req_ready   request handshake; ready only in RUN with no aging sweep pending
//   req_op                0 = lookup, 1 = learn (insert/refresh)
//   req_key, req_hash     48-bit MAC key and its 32-bit hash; index = req_hash[ADDR_W-1:0]
//   req_val               value stored on learn
//   resp_valid            one-cycle response strobe, two cycles after acceptance
//   resp_op/hit/evict/val response fields, all zero while resp_valid is low
//   init_done             table cleared, block operational
//
// Build option: define MAC_HASH_AGING_EN to add per-entry age bits, the aging timer and the
// AGE sweep state. Without it AGE_PERIOD is ignored and entries live until overwritten or reset.
module mac_hash_table #(
    parameter int ADDR_W     = 8,
    parameter int VAL_W      = 8,
    parameter int AGE_PERIOD = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [47:0]      req_key,
    input  logic [31:0]      req_hash,
    input  logic [VAL_W-1:0] req_val,
    output logic             resp_valid,
    output logic             resp_op,
    output logic             resp_hit,
    output logic             resp_evict,
    output logic [VAL_W-1:0] resp_val,
    output logic             init_done
);
    localparam int DEPTH = 1 << ADDR_W;

`ifdef MAC_HASH_AGING_EN
    typedef enum logic [1:0] {S_INIT, S_RUN, S_AGE} state_t;
`else
    typedef enum logic {S_INIT, S_RUN} state_t;
`endif

    state_t            state, state_d;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] idx;
    logic              last;
    logic              accept;
    logic              age_due;
    logic              unused_ok;

    logic [DEPTH-1:0]  valid_q;
    logic [47:0]       key_mem [DEPTH];
    logic [VAL_W-1:0]  val_mem [DEPTH];

    logic              s1_valid, s1_op, rd_valid, hit;
    logic [47:0]       s1_key, rd_key;
    logic [VAL_W-1:0]  rd_val;

    assign idx    = req_hash[ADDR_W-1:0];
    assign last   = cnt == {ADDR_W{1'b1}};
    assign accept = req_valid && req_ready;

    // FSM: state register
    always_ff @(posedge clk)
        state <= reset ? S_INIT : state_d;

    // FSM: next state
    always_comb begin
        state_d = state;
        if (state == S_INIT && last) state_d = S_RUN;
`ifdef MAC_HASH_AGING_EN
        if (state == S_RUN && age_due) state_d = S_AGE;
        if (state == S_AGE && last) state_d = S_RUN;
`endif
    end

    // FSM: outputs; reset gates ready so a request presented during reset is never taken
    always_comb begin
        req_ready = !reset && state == S_RUN && !age_due;
        init_done = state != S_INIT;
    end

    // Shared index walker for the INIT clear and the AGE sweep; parked at 0 in RUN
    always_ff @(posedge clk)
        if (reset || state == S_RUN) cnt <= '0;
        else cnt <= cnt + 1'b1;

    // Key/value storage: read-first, written only by an accepted learn
    always_ff @(posedge clk) begin
        rd_key <= key_mem[idx];
        rd_val <= val_mem[idx];
        s1_key <= req_key;
        if (accept && req_op) begin
            key_mem[idx] <= req_key;
            val_mem[idx] <= req_val;
        end
    end

`ifdef MAC_HASH_AGING_EN
    localparam int TW = $clog2(AGE_PERIOD + 1);

    logic [DEPTH-1:0] age_q;
    logic [TW-1:0]    timer;

    // Valid bits: cleared in INIT, set by learn, dropped in AGE when already stale
    always_ff @(posedge clk) begin
        rd_valid <= valid_q[idx];
        if (state == S_INIT) valid_q[cnt] <= 1'b0;
        else if (accept && req_op) valid_q[idx] <= 1'b1;
        else if (state == S_AGE && !age_q[cnt]) valid_q[cnt] <= 1'b0;
    end

    // Age bits: only a learn refreshes; the sweep clears them one index per cycle
    always_ff @(posedge clk) begin
        if (state == S_INIT) age_q[cnt] <= 1'b0;
        else if (accept && req_op) age_q[idx] <= 1'b1;
        else if (state == S_AGE) age_q[cnt] <= 1'b0;
    end

    // Timer runs only while requests are admitted; age_due holds off requests for one
    // drain cycle before the sweep and is released as the sweep finishes
    always_ff @(posedge clk) begin
        if (reset) begin
            timer   <= '0;
            age_due <= 1'b0;
        end else if (state == S_AGE && last) begin
            age_due <= 1'b0;
        end else if (state == S_RUN && !age_due) begin
            if (timer == TW'(AGE_PERIOD - 1)) begin
                timer   <= '0;
                age_due <= 1'b1;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

    assign unused_ok = ^req_hash[31:ADDR_W];
`else
    always_ff @(posedge clk) begin
        rd_valid <= valid_q[idx];
        if (state == S_INIT) valid_q[cnt] <= 1'b0;
        else if (accept && req_op) valid_q[idx] <= 1'b1;
    end

    assign age_due   = 1'b0;
    assign unused_ok = ^{req_hash[31:ADDR_W], AGE_PERIOD != 0};
`endif

    // Compare stage works on the entry as it was before this request's own write
    assign hit = s1_valid && rd_valid && rd_key == s1_key;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_op      <= 1'b0;
            resp_valid <= 1'b0;
            resp_op    <= 1'b0;
            resp_hit   <= 1'b0;
            resp_evict <= 1'b0;
            resp_val   <= '0;
        end else begin
            s1_valid   <= accept;
            s1_op      <= req_op;
            resp_valid <= s1_valid;
            resp_op    <= s1_valid && s1_op;
            resp_hit   <= hit;
            resp_evict <= s1_valid && s1_op && rd_valid && rd_key != s1_key;
            resp_val   <= hit ? rd_val : '0;
        end
    end
endmodule

// File: tb/tb_mac_hash_table.sv
// tb_mac_hash_table: directed stimulus with a table model and per-cycle output comparison
module tb_mac_hash_table;
    localparam int AP = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_op = 1'b0;
    logic [47:0] req_key = '0;
    logic [31:0] req_hash = '0;
    logic [7:0]  req_val = '0;
    logic        req_ready, resp_valid, resp_op, resp_hit, resp_evict, init_done;
    logic [7:0]  resp_val;

    int checks = 0;
    int errors = 0;

    mac_hash_table #(.ADDR_W(8), .VAL_W(8), .AGE_PERIOD(AP)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_key(req_key), .req_hash(req_hash), .req_val(req_val),
        .resp_valid(resp_valid), .resp_op(resp_op), .resp_hit(resp_hit),
        .resp_evict(resp_evict), .resp_val(resp_val), .init_done(init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    typedef struct {
        int         due;
        logic       op;
        logic       hit;
        logic       evict;
        logic [7:0] val;
    } resp_t;

    resp_t       q[$];
    logic        m_valid [256];
    logic        m_age   [256];
    logic [47:0] m_key   [256];
    logic [7:0]  m_val   [256];
    int          k = 0;
    int          ec = 0;
    int          t = 0;
    int          blk = 0;
    bit          started = 0;

    // Model: reset empties the table; 256 edges of clearing; then each admitted request
    // answers from the table contents and is reported two cycles later
    always @(posedge clk) begin : model
        resp_t e;
        int    i;
        bit    rdy, h;
        started = 1;
        ec++;
        if (reset) begin
            q.delete();
            k = 0;
            t = 0;
            blk = 0;
            for (int j = 0; j < 256; j++) begin
                m_valid[j] = 1'b0;
                m_age[j] = 1'b0;
            end
        end else begin
            rdy = k >= 256 && blk == 0;
            if (rdy && req_valid) begin
                i = int'(req_hash[7:0]);
                h = m_valid[i] && m_key[i] == req_key;
                e.due = ec + 1;
                e.op = req_op;
                e.hit = h;
                e.evict = req_op && m_valid[i] && !h;
                e.val = h ? m_val[i] : 8'h00;
                q.push_back(e);
                if (req_op) begin
                    m_valid[i] = 1'b1;
                    m_age[i] = 1'b1;
                    m_key[i] = req_key;
                    m_val[i] = req_val;
                end
            end
`ifdef MAC_HASH_AGING_EN
            if (blk > 0) blk--;
            else if (rdy) begin
                t++;
                if (t == AP) begin
                    t = 0;
                    blk = 257;
                    for (int j = 0; j < 256; j++)
                        if (m_age[j]) m_age[j] = 1'b0;
                        else m_valid[j] = 1'b0;
                end
            end
`endif
            if (k < 256) k++;
        end
    end

    always @(negedge clk) begin : compare
        logic [13:0] act, expv;
        resp_t e;
        if (started) begin
            expv = {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, !reset && k >= 256 && blk == 0, k >= 256};
            if (q.size() > 0 && q[0].due == ec) begin
                e = q.pop_front();
                expv[13:2] = {1'b1, e.op, e.hit, e.evict, e.val};
            end
            act = {resp_valid, resp_op, resp_hit, resp_evict, resp_val, req_ready, init_done};
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL cycle_outputs edge=%0d got=%h expected=%h", ec, act, expv);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", req_ready, 1);
    endtask

    task automatic init_wait(input string name);
        int n = 0;
        while (!init_done && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, n, 256);
        check({name, "_ready"}, req_ready, 1);
    endtask

    task automatic xact(input string name, input logic op, input logic [47:0] key,
                        input logic [31:0] hash, input logic [7:0] val,
                        input logic e_hit, input logic e_evict, input logic [7:0] e_val);
        wait_ready();
        req_valid = 1'b1;
        req_op = op;
        req_key = key;
        req_hash = hash;
        req_val = val;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check(name, {resp_valid, resp_op, resp_hit, resp_evict, resp_val},
              {1'b1, op, e_hit, e_evict, e_val});
    endtask

`ifdef MAC_HASH_AGING_EN
    task automatic wait_sweep(input string name);
        int n = 0;
        int m = 0;
        while (req_ready && n < 1500) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_start"}, req_ready, 0);
        while (!req_ready && m < 600) begin
            @(posedge clk); #1;
            m++;
        end
        check(name, m, 257);
    endtask
`endif

    localparam logic [47:0] KA = 48'h001122334455;
    localparam logic [47:0] KB = 48'h0A0B0C0D0E0F;
    localparam logic [47:0] KC = 48'h0000DEADBEEF;
    localparam logic [47:0] KD = 48'h665544332211;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        init_wait("init_len");

        xact("learn_a", 1'b1, KA, 32'h123456AB, 8'h04, 1'b0, 1'b0, 8'h00);
        xact("lookup_a", 1'b0, KA, 32'h123456AB, 8'h00, 1'b1, 1'b0, 8'h04);
        xact("learn_b_evict", 1'b1, KB, 32'hFFFF00AB, 8'h08, 1'b0, 1'b1, 8'h00);
        xact("lookup_a_gone", 1'b0, KA, 32'h123456AB, 8'h00, 1'b0, 1'b0, 8'h00);
        xact("lookup_b", 1'b0, KB, 32'hFFFF00AB, 8'h00, 1'b1, 1'b0, 8'h08);

        wait_ready();
        req_valid = 1'b1; req_op = 1'b1; req_key = KC; req_hash = 32'h00000010; req_val = 8'h02;
        @(posedge clk); #1;
        req_op = 1'b0; req_val = 8'h00;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("b2b_learn", {resp_valid, resp_op, resp_hit, resp_evict, resp_val}, {4'b1100, 8'h00});
        @(posedge clk); #1;
        check("b2b_lookup", {resp_valid, resp_op, resp_hit, resp_evict, resp_val}, {4'b1010, 8'h02});

        xact("relearn_c", 1'b1, KC, 32'h00000010, 8'h05, 1'b1, 1'b0, 8'h02);
        xact("lookup_c_new", 1'b0, KC, 32'h00000010, 8'h00, 1'b1, 1'b0, 8'h05);

        wait_ready();
        req_valid = 1'b1; req_op = 1'b1; req_key = KD; req_hash = 32'h00000020; req_val = 8'h09;
        @(posedge clk); #1;
        req_op = 1'b0; req_val = 8'h00;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_discard", resp_valid, 0);
        reset = 1'b0;
        init_wait("reinit_len");
        req_valid = 1'b0;
        xact("lookup_d_after_reset", 1'b0, KD, 32'h00000020, 8'h00, 1'b0, 1'b0, 8'h00);
        xact("lookup_c_after_reset", 1'b0, KC, 32'h00000010, 8'h00, 1'b0, 1'b0, 8'h00);

`ifdef MAC_HASH_AGING_EN
        xact("age_learn_x", 1'b1, 48'h111111111111, 32'h00000030, 8'h11, 1'b0, 1'b0, 8'h00);
        xact("age_learn_y", 1'b1, 48'h222222222222, 32'h00000031, 8'h22, 1'b0, 1'b0, 8'h00);
        wait_sweep("sweep1_len");
        xact("age_relearn_y", 1'b1, 48'h222222222222, 32'h00000031, 8'h23, 1'b1, 1'b0, 8'h22);
        wait_sweep("sweep2_len");
        xact("age_x_expired", 1'b0, 48'h111111111111, 32'h00000030, 8'h00, 1'b0, 1'b0, 8'h00);
        xact("age_y_kept", 1'b0, 48'h222222222222, 32'h00000031, 8'h00, 1'b1, 1'b0, 8'h23);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_hash_table.md
# mac_hash_table

Single-port MAC learning/lookup table indexed by the 32-bit one-at-a-time hash of a 48-bit MAC key. It sits downstream of the pipelined MAC hasher in the output-port-lookup path. The requester aligns each key with its hash and issues learn (insert/refresh) or lookup requests. The block returns hit/miss plus the stored value, typically an output-port bitmap, at a fixed 2-cycle latency.

## Interface
- ADDR_W, 8: table index width; 2^ADDR_W entries; index = req_hash[ADDR_W-1:0]
- VAL_W, 8: stored value width
- AGE_PERIOD, 1000000: cycles between aging sweeps; used only with aging compiled in
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_op  in  1  0 = lookup, 1 = learn
- req_key  in  48  MAC key
- req_hash  in  32  hash of req_key from the hasher; the requester aligns it
- req_val  in  VAL_W  value to store on learn
- resp_valid  out  1  one-cycle response strobe
- resp_op  out  1  op of the responding request
- resp_hit  out  1  entry valid and key equal
- resp_evict  out  1  learn overwrote a valid entry with a different key
- resp_val  out  VAL_W  stored value on hit; pre-write value on learn hit; 0 otherwise
- init_done  out  1  table cleared, block operational

## Operation
- Entry = {valid, key[47:0], val[VAL_W-1:0]}, plus age bit when aging is enabled.
- FSM states: INIT, RUN, AGE (AGE exists only with aging).
- INIT: entered on reset. An index counter runs 0..2^ADDR_W-1, writing one invalid entry per cycle. After the last write the FSM moves to RUN and init_done rises.
- req_ready = (state == RUN) && !age_due. A request is accepted when req_valid && req_ready.
- On acceptance the block reads entry[idx] with read-first semantics.
  - Learn: writes {1, req_key, req_val} on the same edge, with age = 1.
  - Lookup: no write.
- The response is computed from the old entry:
  - Lookup: hit = valid && key == req_key.
  - Learn: hit as for lookup; evict = valid && key != req_key.
- Signals are driven only while resp_valid = 1. Otherwise resp_hit, resp_evict and resp_val are 0.
- Responses have no backpressure; the consumer must always sink them.
- resp_op mirrors the request's req_op.

## Timing
- Reset values: req_ready 0, resp_valid 0, resp_op 0, resp_hit 0, resp_evict 0, resp_val 0, init_done 0.
- INIT lasts exactly 2^ADDR_W cycles after reset deasserts. req_ready first rises in the cycle after the final clear.
- Latency: a request accepted in cycle n produces resp_valid in cycle n+2.
  - Pipeline: read register at the edge ending n, compare register at the edge ending n+1.
- Throughput: 1 request per cycle in RUN.
- Back-to-back requests to the same index: a learn in cycle n is visible to a request accepted in cycle n+1. No hazard.
- Reset mid-operation:
  - In-flight responses are discarded, resp_valid = 0 from the next cycle.
  - The table is re-cleared via INIT.
  - A request presented during reset is not accepted.
- Full table: no full state. Collisions overwrite and are reported via resp_evict.

## Configuration
- MAC_HASH_AGING_EN defined:
  - Each entry carries an age bit.
  - A timer counts cycles in RUN. At AGE_PERIOD-1 it sets age_due; req_ready drops the next cycle, and the FSM enters AGE one cycle later.
  - AGE sweeps indices 0..2^ADDR_W-1, one per cycle. Entries with age = 1 have age cleared; entries with age = 0 have valid cleared.
  - The sweep then returns to RUN, clears age_due and restarts the timer.
  - Learn and lookup hits are unaffected during the sweep's pipeline drain.
  - A lookup hit does not refresh age; only learn does.
- MAC_HASH_AGING_EN undefined: no age bits, no timer, no AGE state. AGE_PERIOD is ignored and entries persist until overwritten or reset.

## Test plan
- Reset release, ADDR_W=8 → init_done and req_ready stay 0 for 256 cycles, then rise together; all outputs 0 throughout.
- Learn key 0x001122334455, hash 0x123456AB, val 0x04 → cycle n+2: resp_op 1, hit 0, evict 0. A lookup of the same key/hash then returns hit 1, val 0x04.
- Learn key 0x0A0B0C0D0E0F, hash 0xFFFF00AB, val 0x08 after the previous entry → evict 1, hit 0. A lookup of 0x001122334455 then gives hit 0, val 0.
- Learn (idx 0x10, val 0x02) in cycle n, then a lookup of the same key in cycle n+1 → responses in n+2 and n+3; the lookup returns hit 1, val 0x02.
- Assert reset for one cycle with two requests in flight → no resp_valid afterwards. A 256-cycle INIT follows, and a lookup of a previously learned key misses.
- With MAC_HASH_AGING_EN and AGE_PERIOD=1000:
  - A key learned once and not relearned misses after the second sweep.
  - A key relearned between sweeps still hits.
  - req_ready stays 0 for each sweep plus one cycle.
